// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 demux sequencing controller.
package demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_FIX = 1'b1;

endpackage

// File: rtl/demux_1_4_bus.sv
// Combinational 1-to-4 steering: the selected slice carries din, all others are zero.
module demux_1_4_bus
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]       din,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   en,
  output logic [N_OUT*WIDTH-1:0] dout,
  output logic [N_OUT-1:0]       vld
);

  // Data is steered even when en is low; only the valid strobe is gated.
  always_comb begin
    dout = '0;
    vld  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (sel == SEL_W'(k)) begin
        dout[k*WIDTH +: WIDTH] = din;
        vld[k]                 = en;
      end
    end
  end

endmodule

// File: rtl/demux_1_4_sched.sv
// Handshaked scheduler feeding one producer's words to four sinks, round-robin or fixed,
// with a per-output transfer counter.
module demux_1_4_sched
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       fix_sel,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [SEL_W-1:0]       cur_sel,
  output logic [N_OUT*CNT_W-1:0] cnt
);

  state_t           state;
  logic [SEL_W-1:0] tgt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_post;
  logic [SEL_W-1:0] nxt;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] cnt_r [N_OUT];
  logic             accept;
  logic             xfer;

  assign in_ready = ~rst & ((state == S_IDLE) | out_ready[tgt]);
  assign xfer     = (state == S_HOLD) & out_ready[tgt];
  assign accept   = in_valid & in_ready;

  // A word captured in the same cycle as a round-robin transfer must see the advanced pointer.
  assign rr_post = (xfer && mode == MODE_RR) ? tgt + SEL_W'(1) : rr_ptr;
  assign nxt     = (mode == MODE_FIX) ? fix_sel : rr_post;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tgt      <= '0;
      rr_ptr   <= '0;
      data_reg <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      if (xfer) begin
        cnt_r[tgt] <= cnt_r[tgt] + CNT_W'(1);
        if (mode == MODE_RR) begin
          rr_ptr <= rr_post;
        end
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_HOLD;
            data_reg <= in_data;
            tgt      <= nxt;
          end
        end
        S_HOLD: begin
          if (accept) begin
            data_reg <= in_data;
            tgt      <= nxt;
          end else if (xfer) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < N_OUT; k++) begin
      cnt[k*CNT_W +: CNT_W] = cnt_r[k];
    end
  end

  assign cur_sel = tgt;

  demux_1_4_bus #(
    .WIDTH(WIDTH)
  ) u_bus (
    .din (data_reg),
    .sel (tgt),
    .en  (state == S_HOLD),
    .dout(out_data),
    .vld (out_valid)
  );

endmodule

// File: tb/tb_demux_1_4_sched.sv
// Scoreboard bench for demux_1_4_sched: directed words with hand-assigned target ports.
module tb_demux_1_4_sched;
  import demux_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;
  logic [1:0]             fix_sel;
  logic [4*WIDTH-1:0]     out_data;
  logic [3:0]             out_valid;
  logic [3:0]             out_ready;
  logic [1:0]             cur_sel;
  logic [4*CNT_W-1:0]     cnt;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  demux_1_4_sched #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .fix_sel  (fix_sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cur_sel  (cur_sel),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake on an output retires the oldest expected word.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] want;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_xfer: output %0d data 0x%0h with empty scoreboard", k, out_data);
          end else begin
            e    = exp_q.pop_front();
            want = 32'(e.data) << (8 * e.port);
            check_output("xfer_port", 32'(k), 32'(e.port));
            check_output("xfer_data", out_data, want);
            check_output("xfer_cur_sel", 32'(cur_sel), 32'(e.port));
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] p, input bit want_now);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: word 0x%0h never accepted", d);
    end else begin
      exp_q.push_back('{port: p, data: d});
      if (want_now) check_output("accept_wait", 32'(n), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    mode      = MODE_RR;
    fix_sel   = 2'd0;
    out_ready = 4'hF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_cnt", cnt, 32'd0);
    check_output("rst_cur_sel", 32'(cur_sel), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin, all sinks ready: 0,1,2,3,0 with no stalls.
    apply_stimulus(8'h11, 2'd0, 1'b1);
    apply_stimulus(8'h22, 2'd1, 1'b1);
    apply_stimulus(8'h33, 2'd2, 1'b1);
    apply_stimulus(8'h44, 2'd3, 1'b1);
    apply_stimulus(8'h55, 2'd0, 1'b1);
    idle(3);
    check_output("rr_cnt", cnt, 32'h01010102);

    // Backpressure on output 1.
    out_ready = 4'b1101;
    apply_stimulus(8'h22, 2'd1, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check_output("bp_out_valid", 32'(out_valid), 32'h2);
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
      check_output("bp_out_data", out_data, 32'h00002200);
      @(posedge clk);
    end
    #1;
    out_ready = 4'hF;
    apply_stimulus(8'h66, 2'd2, 1'b1);
    idle(3);
    check_output("bp_cnt", cnt, 32'h01020202);

    // Fixed mode to output 2; retargeting while held must not move the held word.
    mode    = MODE_FIX;
    fix_sel = 2'd2;
    apply_stimulus(8'h71, 2'd2, 1'b1);
    apply_stimulus(8'h72, 2'd2, 1'b1);
    apply_stimulus(8'h73, 2'd2, 1'b1);
    idle(2);
    out_ready = 4'b1011;
    apply_stimulus(8'h74, 2'd2, 1'b1);
    fix_sel = 2'd3;
    repeat (2) begin
      @(negedge clk);
      check_output("fix_hold_valid", 32'(out_valid), 32'h4);
      check_output("fix_hold_sel", 32'(cur_sel), 32'd2);
      @(posedge clk);
    end
    #1;
    out_ready = 4'hF;
    idle(2);
    check_output("fix_cnt", cnt, 32'h01060202);
    mode = MODE_RR;
    apply_stimulus(8'h80, 2'd3, 1'b1);
    idle(2);
    check_output("rr_resume_cnt", cnt, 32'h02060202);

    // Counter wrap on output 3 (starts at 2).
    mode    = MODE_FIX;
    fix_sel = 2'd3;
    for (int i = 0; i < 254; i++) apply_stimulus(8'(i), 2'd3, 1'b0);
    idle(2);
    check_output("cnt3_wrap", 32'(cnt[31:24]), 32'd0);
    apply_stimulus(8'hE1, 2'd3, 1'b1);
    apply_stimulus(8'hE2, 2'd3, 1'b1);
    idle(2);
    check_output("cnt_after_wrap", cnt, 32'h02060202);
    mode = MODE_RR;
    apply_stimulus(8'hA0, 2'd0, 1'b1);
    idle(2);
    check_output("pre_rst_cnt", cnt, 32'h02060203);

    // Reset while a word is held on output 1: word is dropped, nothing counted.
    out_ready = 4'h0;
    apply_stimulus(8'hAA, 2'd1, 1'b1);
    void'(exp_q.pop_back());
    @(negedge clk);
    check_output("held_valid", 32'(out_valid), 32'h2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_cnt", cnt, 32'd0);
    check_output("midrst_cur_sel", 32'(cur_sel), 32'd0);
    check_output("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 4'hF;
    apply_stimulus(8'hBB, 2'd0, 1'b1);
    idle(2);
    check_output("post_rst_cnt", cnt, 32'h00000001);

    check_output("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
